// File: rtl/ex_if.sv
// ---------------------------------------------------------------------------
// ex_if : ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
//
// master : pipeline side; drives the decoded instruction, receives results.
// slave  : execute stage; receives the instruction, drives results.
//
// Signals
//   aluop_i    operation code               reg1_i / reg2_i  operands A / B
//   wd_i       destination register         wreg_i           destination write enable
//   flush_i    annul instruction / abort divide
//   wd_o, wreg_o, wdata_o     register-file write towards EX/MEM
//   whilo_o, hi_o, lo_o       HI/LO write (one-cycle pulse)
//   stallreq_o                freeze PC, IF/ID and ID/EX
// ---------------------------------------------------------------------------
interface ex_if #(
  parameter int AluOpW = 8
);
  logic [AluOpW-1:0] aluop_i;
  logic [31:0]       reg1_i;
  logic [31:0]       reg2_i;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic              flush_i;

  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [31:0]       wdata_o;
  logic              whilo_o;
  logic [31:0]       hi_o;
  logic [31:0]       lo_o;
  logic              stallreq_o;

  modport master (
    output aluop_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex.sv
// ---------------------------------------------------------------------------
// ex : MIPS32 execute stage.
//
// Logic, shift, add/sub and compare ops are purely combinational. DIV/DIVU
// run on a 32-step restoring divider (one quotient bit per cycle) and hold
// the pipeline with stallreq_o until the END cycle, where HI/LO are written.
//
// Ports
//   clk  pipeline clock (rising edge)
//   rst  asynchronous active-low reset; all outputs read 0 while low
//   bus  ex_if.slave : instruction in, register-file / HI-LO results out
// ---------------------------------------------------------------------------
module ex (
  input  logic clk,
  input  logic rst,
  ex_if.slave  bus
);

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [31:0] dividend_reg;   // |A|, shifted left one bit per step
  logic [31:0] divisor_reg;    // |B|
  logic [31:0] rem_reg;
  logic [31:0] quot_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;

  logic [31:0] a, b;
  logic [31:0] alu_res;
  logic        is_div, is_signed;
  logic        stall, whilo, start_on, start_zero;

  assign a = bus.reg1_i;
  assign b = bus.reg2_i;

  // Combinational ALU and op decode
  always_comb begin
    alu_res   = '0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (bus.aluop_i)
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADDU: alu_res = a + b;
      OP_SUBU: alu_res = a - b;
      OP_SLT:  alu_res = {31'b0, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {31'b0, (a < b)};
      OP_SLL:  alu_res = b << a[4:0];
      OP_SRL:  alu_res = b >> a[4:0];
      OP_SRA:  alu_res = $unsigned($signed(b) >>> a[4:0]);
      OP_DIV:  begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU: is_div = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // Divider FSM: next state and raw control outputs
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    whilo      = 1'b0;
    start_on   = 1'b0;
    start_zero = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (is_div && !bus.flush_i) begin
          stall = 1'b1;
          if (b == 32'd0) begin
            state_next = S_BYZERO;
            start_zero = 1'b1;
          end else begin
            state_next = S_ON;
            start_on   = 1'b1;
          end
        end
      end
      S_ON: begin
        stall = 1'b1;
        if (cnt_reg == 5'd31) state_next = S_END;
      end
      S_BYZERO: begin
        stall      = 1'b1;
        state_next = S_END;
      end
      S_END: begin
        whilo      = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // A flush abandons whatever the divider was doing
    if (bus.flush_i) state_next = S_IDLE;
  end

  // One restoring step: the borrow out of the 33-bit subtraction tells
  // whether the partial remainder was below the divisor.
  logic [32:0] partial, diff;
  logic        q_bit;
  assign partial = {rem_reg, dividend_reg[31]};
  assign diff    = partial - {1'b0, divisor_reg};
  assign q_bit   = ~diff[32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_on) begin
        dividend_reg <= (is_signed && a[31]) ? (~a + 32'd1) : a;
        divisor_reg  <= (is_signed && b[31]) ? (~b + 32'd1) : b;
        neg_q_reg    <= is_signed & (a[31] ^ b[31]);
        neg_r_reg    <= is_signed & a[31];
        rem_reg      <= '0;
        quot_reg     <= '0;
        cnt_reg      <= '0;
      end else if (start_zero) begin
        rem_reg   <= '0;
        quot_reg  <= '0;
        neg_q_reg <= 1'b0;
        neg_r_reg <= 1'b0;
      end else if (state_reg == S_ON && !bus.flush_i) begin
        rem_reg      <= q_bit ? diff[31:0] : partial[31:0];
        quot_reg     <= {quot_reg[30:0], q_bit};
        dividend_reg <= {dividend_reg[30:0], 1'b0};
        cnt_reg      <= cnt_reg + 5'd1;
      end
    end
  end

  // Output gating: reset zeroes everything, flush kills the side effects
  logic live, whilo_out;
  assign live      = rst;
  assign whilo_out = live & whilo & ~bus.flush_i;

  assign bus.wd_o       = live ? bus.wd_i : 5'd0;
  assign bus.wreg_o     = live & bus.wreg_i & ~is_div & ~bus.flush_i;
  assign bus.wdata_o    = live ? alu_res : 32'd0;
  assign bus.stallreq_o = live & stall & ~bus.flush_i;
  assign bus.whilo_o    = whilo_out;
  assign bus.lo_o       = whilo_out ? (neg_q_reg ? (~quot_reg + 32'd1) : quot_reg) : 32'd0;
  assign bus.hi_o       = whilo_out ? (neg_r_reg ? (~rem_reg + 32'd1) : rem_reg) : 32'd0;

endmodule

// File: tb/tb_ex.sv
// ---------------------------------------------------------------------------
// tb_ex : self-checking bench for the execute stage.
// Directed steps from the test plan plus randomized ALU ops and divides,
// checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_if bus ();
  ex u_dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] NOP = 8'h00, OR_ = 8'h25, AND_ = 8'h24, XOR_ = 8'h26, NOR_ = 8'h27;
  localparam logic [7:0] ADDU = 8'h21, SUBU = 8'h23, SLT = 8'h2A, SLTU = 8'h2B;
  localparam logic [7:0] SLL = 8'h7C, SRL = 8'h02, SRA = 8'h03, DIV = 8'h1A, DIVU = 8'h1B;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic
  function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p2, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p2 = 1;
    for (int i = 0; i < int'(a[4:0]); i++) p2 = p2 * 2;
    case (op)
      OR_:  return a | b;
      AND_: return a & b;
      XOR_: return a ^ b;
      NOR_: return ~(a | b);
      ADDU: return 32'(ua + ub);
      SUBU: return 32'(ua - ub);
      SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      SLTU: return (ua < ub) ? 32'd1 : 32'd0;
      SLL:  return 32'(ub * p2);
      SRL:  return 32'(ub / p2);
      SRA: begin
        if (sb >= 0) r = sb / p2;
        else r = -((-sb + p2 - 1) / p2);
        return 32'(r);
      end
      default: return 32'd0;
    endcase
  endfunction

  // Reference divide: truncating quotient, remainder takes dividend's sign
  task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint x, y;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0;
    end else begin
      x = sgn ? longint'($signed(a)) : longint'(a);
      y = sgn ? longint'($signed(b)) : longint'(b);
      q = 32'(x / y);
      r = 32'(x % y);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr);
    bus.aluop_i = op;
    bus.reg1_i  = a;
    bus.reg2_i  = b;
    bus.wd_i    = wd;
    bus.wreg_i  = wr;
    bus.flush_i = 1'b0;
  endtask

  // One combinational op: drive after a rising edge, sample at the falling edge
  task automatic comb_test(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] wd;
    logic       wr;
    wd = 5'($urandom_range(1, 31));
    wr = 1'($urandom_range(0, 1));
    drive(op, a, b, wd, wr);
    @(negedge clk);
    $display("txn %s op=%h a=%h b=%h wdata=%h", tag, op, a, b, bus.wdata_o);
    check({tag, "_wdata"}, bus.wdata_o, model_alu(op, a, b));
    check({tag, "_wreg"}, 32'(bus.wreg_o), 32'(wr));
    check({tag, "_wd"}, 32'(bus.wd_o), 32'(wd));
    check({tag, "_stall"}, 32'(bus.stallreq_o), 32'd0);
    check({tag, "_whilo"}, 32'(bus.whilo_o), 32'd0);
    @(posedge clk); #1;
  endtask

  // Present a divide and hold it until whilo pulses (bounded)
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int pulse,
                         output logic [31:0] hi, output logic [31:0] lo, output logic wr);
    stalls = 0; pulse = -1; hi = 'x; lo = 'x; wr = 1'bx;
    drive(op, a, b, 5'd9, 1'b1);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.stallreq_o) stalls++;
      if (bus.whilo_o) begin
        pulse = c; hi = bus.hi_o; lo = bus.lo_o; wr = bus.wreg_o;
      end
      @(posedge clk); #1;
      if (pulse > 0) break;
    end
    bus.aluop_i = NOP;
  endtask

  task automatic div_test(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int pulse);
    int stalls;
    logic [31:0] hi, lo, eq, er;
    logic wr;
    run_div(op, a, b, stalls, pulse, hi, lo, wr);
    model_div(op == DIV, a, b, eq, er);
    $display("txn %s op=%h a=%h b=%h stalls=%0d pulse=%0d hi=%h lo=%h", tag, op, a, b, stalls, pulse, hi, lo);
    check({tag, "_stalls"}, 32'(stalls), (b == 0) ? 32'd2 : 32'd33);
    check({tag, "_pulse"}, 32'(pulse), (b == 0) ? 32'd3 : 32'd34);
    check({tag, "_lo"}, lo, eq);
    check({tag, "_hi"}, hi, er);
    check({tag, "_wreg"}, 32'(wr), 32'd0);
  endtask

  initial begin
    logic [7:0] comb_ops [13];
    int p1, p2, pulses;
    logic [31:0] ra, rb;
    logic [7:0]  rop;
    comb_ops = '{NOP, OR_, AND_, XOR_, NOR_, ADDU, SUBU, SLT, SLTU, SLL, SRL, SRA, 8'hFF};

    // Reset state: outputs zero regardless of the presented instruction
    rst = 1'b0;
    drive(OR_, 32'h0000FF00, 32'h00FF0000, 5'd5, 1'b1);
    #3;
    check("rst_wdata", bus.wdata_o, 32'd0);
    check("rst_wd", 32'(bus.wd_o), 32'd0);
    check("rst_wreg", 32'(bus.wreg_o), 32'd0);
    check("rst_stall", 32'(bus.stallreq_o), 32'd0);
    check("rst_whilo", 32'(bus.whilo_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed ALU ops and compares
    comb_test("or", OR_, 32'h0000FF00, 32'h00FF0000);
    check("or_value", model_alu(OR_, 32'h0000FF00, 32'h00FF0000), 32'h00FFFF00);
    comb_test("subu", SUBU, 32'd0, 32'd1);
    comb_test("sra", SRA, 32'd4, 32'h80000000);
    comb_test("slt", SLT, 32'hFFFFFFFF, 32'd1);
    comb_test("sltu", SLTU, 32'hFFFFFFFF, 32'd1);
    comb_test("sll31", SLL, 32'd31, 32'h00000003);
    comb_test("nop", NOP, 32'h12345678, 32'h9ABCDEF0);

    // Randomized combinational ops
    for (int i = 0; i < 40; i++) begin
      rop = comb_ops[$urandom_range(0, 12)];
      comb_test("rnd_alu", rop, $urandom, $urandom);
    end

    // Directed divides
    div_test("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, p1);
    div_test("divu_big", DIVU, 32'hFFFFFFFF, 32'h10, p1);
    div_test("div_by0", DIV, 32'd5, 32'd0, p1);
    div_test("div_minint", DIV, 32'h80000000, 32'hFFFFFFFF, p1);

    // Back-to-back: second pulse 68 cycles after the first divide starts
    div_test("b2b_1", DIVU, 32'd100, 32'd7, p1);
    div_test("b2b_2", DIVU, 32'd9, 32'd3, p2);
    check("b2b_total", 32'(p1 + p2), 32'd68);

    // Randomized divides
    for (int i = 0; i < 6; i++) begin
      rop = ($urandom_range(0, 1) == 0) ? DIV : DIVU;
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 200)) : $urandom;
      if ((i % 2 == 0) && ($urandom_range(0, 1) == 1)) rb = -rb;
      div_test("rnd_div", rop, ra, rb, p1);
    end

    // Flush at ON cycle 10: stall drops at once, no HI/LO write follows
    drive(DIVU, 32'd1000, 32'd3, 5'd4, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("flush_pre_stall", 32'(bus.stallreq_o), 32'd1);
    bus.flush_i = 1'b1;
    #1;
    check("flush_stall", 32'(bus.stallreq_o), 32'd0);
    check("flush_whilo", 32'(bus.whilo_o), 32'd0);
    check("flush_wreg", 32'(bus.wreg_o), 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.aluop_i = NOP;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.whilo_o) pulses++;
    end
    $display("txn flush pulses_after=%0d", pulses);
    check("flush_no_pulse", 32'(pulses), 32'd0);
    check("flush_idle_stall", 32'(bus.stallreq_o), 32'd0);
    @(posedge clk); #1;

    // Reset at ON cycle 20, then the held DIV restarts from scratch
    drive(DIV, 32'hFFFFFF9C, 32'd7, 5'd3, 1'b1);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_stall", 32'(bus.stallreq_o), 32'd0);
    check("arst_whilo", 32'(bus.whilo_o), 32'd0);
    check("arst_wd", 32'(bus.wd_o), 32'd0);
    check("arst_hi", bus.hi_o, 32'd0);
    check("arst_lo", bus.lo_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    div_test("arst_div", DIV, 32'hFFFFFF9C, 32'd7, p1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
